// File: rtl/pdm_wavetable_scheduler.sv
// pdm_wavetable_scheduler
// Shares one synchronous-read wavetable ROM among NUM_CH emulated PDM mics.
// Each channel has a double buffer: cur is serialised MSB-first and nxt is
// refilled from the ROM in fixed-length fetch slots. The PDM bit clock is
// derived from clk.
module pdm_wavetable_scheduler #(
   parameter int NUM_CH  = 4,
   parameter int ADDR_W  = 14,
   parameter int WT_SIZE = 1000,
   parameter int CLK_DIV = 50,
   parameter int RD_LAT  = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [NUM_CH*ADDR_W-1:0] ch_offset,
   output logic [ADDR_W-1:0]        rom_addr,
   input  logic [7:0]               rom_q,
   output logic                     pdm_clk,
   output logic [NUM_CH-1:0]        pdm_out,
   output logic                     busy,
   output logic                     overrun
);

   localparam int NSLOT  = 2 * NUM_CH;
   localparam int SLOT_W = $clog2(NSLOT);
   localparam int SUB_W  = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
   localparam int DIV_W  = $clog2(CLK_DIV);
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [ADDR_W-1:0] LAST_A        = ADDR_W'(WT_SIZE - 1);
   localparam logic [ADDR_W:0]   SIZE_A        = (ADDR_W + 1)'(WT_SIZE);
   localparam logic [SUB_W-1:0]  SUB_LAST      = SUB_W'(RD_LAT);
   localparam logic [DIV_W-1:0]  DIV_LAST      = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_HALF      = DIV_W'(CLK_DIV / 2);
   localparam logic [SLOT_W-1:0] SLOT_PRIME_LT = SLOT_W'(NSLOT - 1);
   localparam logic [SLOT_W-1:0] SLOT_RF_LT    = SLOT_W'(NUM_CH - 1);

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q [NUM_CH];
   logic [ADDR_W-1:0]   ptr_d [NUM_CH];
   logic [7:0]          cur_q [NUM_CH];
   logic [7:0]          cur_d [NUM_CH];
   logic [7:0]          nxt_q [NUM_CH];
   logic [7:0]          nxt_d [NUM_CH];
   logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
   logic                pdm_clk_q, pdm_clk_d;
   logic [NUM_CH-1:0]   pdm_out_q, pdm_out_d;
   logic                busy_q, busy_d;
   logic                overrun_q, overrun_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [2:0]          bit_idx_q, bit_idx_d;
   logic                fetch_q, fetch_d;       // a ROM read is outstanding
   logic                rf_start_q, rf_start_d; // refill begins on the next edge
   logic [SUB_W-1:0]    sub_q, sub_d;           // cycles since address issue
   logic [SLOT_W-1:0]   slot_q, slot_d;

   logic bit_tick;
   logic prime_done;
   int unsigned nslot;

   function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
      return (a == LAST_A) ? '0 : a + ADDR_W'(1);
   endfunction

   function automatic logic [ADDR_W-1:0] sanitize(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} >= SIZE_A) ? '0 : a;
   endfunction

   assign bit_tick   = (div_q == DIV_LAST);
   assign prime_done = (state_q == PRIME) && (sub_q == SUB_LAST) && (slot_q == SLOT_PRIME_LT);

   // FSM next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable) state_d = PRIME;
         PRIME:   if (prime_done) state_d = RUN;
         default: ;
      endcase
      if (!enable) state_d = IDLE;
   end

   // datapath next-state: slot fetches, divider, serialiser and buffer swap
   always_comb begin
      ptr_d      = ptr_q;
      cur_d      = cur_q;
      nxt_d      = nxt_q;
      rom_addr_d = rom_addr_q;
      pdm_clk_d  = pdm_clk_q;
      pdm_out_d  = pdm_out_q;
      busy_d     = busy_q;
      overrun_d  = overrun_q;
      div_d      = div_q;
      bit_idx_d  = bit_idx_q;
      fetch_d    = fetch_q;
      rf_start_d = rf_start_q;
      sub_d      = sub_q;
      slot_d     = slot_q;
      nslot      = 0;

      case (state_q)
         IDLE: begin
            if (enable) begin
               for (int unsigned i = 0; i < NUM_CH; i++)
                  ptr_d[i] = sanitize(ch_offset[i*ADDR_W +: ADDR_W]);
               // first slot issues straight from the sanitised offset
               rom_addr_d = ptr_d[0];
               busy_d     = 1'b1;
               fetch_d    = 1'b1;
               sub_d      = '0;
               slot_d     = '0;
            end
         end

         PRIME: begin
            if (sub_q == SUB_LAST) begin
               if (32'(slot_q) < NUM_CH) cur_d[CH_W'(slot_q)] = rom_q;
               else                      nxt_d[CH_W'(32'(slot_q) - NUM_CH)] = rom_q;
               if (slot_q == SLOT_PRIME_LT) begin
                  busy_d    = 1'b0;
                  fetch_d   = 1'b0;
                  div_d     = '0;
                  pdm_clk_d = 1'b1;
                  bit_idx_d = 3'd7;
                  for (int unsigned i = 0; i < NUM_CH; i++) pdm_out_d[i] = cur_d[i][7];
               end else begin
                  // capture and next issue share one edge, so a slot is RD_LAT+1 cycles
                  slot_d = slot_q + 1'b1;
                  sub_d  = '0;
                  nslot  = 32'(slot_q) + 1;
                  if (nslot >= NUM_CH) rom_addr_d = wrap_inc(ptr_q[CH_W'(nslot - NUM_CH)]);
                  else                 rom_addr_d = ptr_q[CH_W'(nslot)];
               end
            end else begin
               sub_d = sub_q + 1'b1;
            end
         end

         RUN: begin
            div_d     = bit_tick ? '0 : div_q + 1'b1;
            pdm_clk_d = (div_d < DIV_HALF);

            if (rf_start_q) begin
               rf_start_d = 1'b0;
               fetch_d    = 1'b1;
               sub_d      = '0;
               slot_d     = '0;
               rom_addr_d = wrap_inc(ptr_q[0]);
            end else if (fetch_q) begin
               if (sub_q == SUB_LAST) begin
                  nxt_d[CH_W'(slot_q)] = rom_q;
                  if (slot_q == SLOT_RF_LT) begin
                     fetch_d = 1'b0;
                  end else begin
                     slot_d     = slot_q + 1'b1;
                     sub_d      = '0;
                     nslot      = 32'(slot_q) + 1;
                     rom_addr_d = wrap_inc(ptr_q[CH_W'(nslot)]);
                  end
               end else begin
                  sub_d = sub_q + 1'b1;
               end
            end

            if (bit_tick) begin
               if (bit_idx_q != '0) begin
                  bit_idx_d = bit_idx_q - 3'd1;
                  for (int unsigned i = 0; i < NUM_CH; i++)
                     pdm_out_d[i] = cur_q[i][bit_idx_q - 3'd1];
               end else begin
                  // a swap abandons any refill in flight and restarts it from ch 0
                  if (fetch_q || rf_start_q) overrun_d = 1'b1;
                  bit_idx_d  = 3'd7;
                  fetch_d    = 1'b0;
                  rf_start_d = 1'b1;
                  for (int unsigned i = 0; i < NUM_CH; i++) begin
                     cur_d[i]     = nxt_q[i];
                     ptr_d[i]     = wrap_inc(ptr_q[i]);
                     pdm_out_d[i] = nxt_q[i][7];
                  end
               end
            end
         end

         default: ;
      endcase

      if (!enable) begin
         rom_addr_d = '0;
         pdm_clk_d  = 1'b0;
         pdm_out_d  = '0;
         busy_d     = 1'b0;
         div_d      = '0;
         bit_idx_d  = 3'd7;
         fetch_d    = 1'b0;
         rf_start_d = 1'b0;
         sub_d      = '0;
         slot_d     = '0;
      end
   end

   // state and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         ptr_q      <= '{default: '0};
         cur_q      <= '{default: '0};
         nxt_q      <= '{default: '0};
         rom_addr_q <= '0;
         pdm_clk_q  <= 1'b0;
         pdm_out_q  <= '0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
         div_q      <= '0;
         bit_idx_q  <= 3'd7;
         fetch_q    <= 1'b0;
         rf_start_q <= 1'b0;
         sub_q      <= '0;
         slot_q     <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cur_q      <= cur_d;
         nxt_q      <= nxt_d;
         rom_addr_q <= rom_addr_d;
         pdm_clk_q  <= pdm_clk_d;
         pdm_out_q  <= pdm_out_d;
         busy_q     <= busy_d;
         overrun_q  <= overrun_d;
         div_q      <= div_d;
         bit_idx_q  <= bit_idx_d;
         fetch_q    <= fetch_d;
         rf_start_q <= rf_start_d;
         sub_q      <= sub_d;
         slot_q     <= slot_d;
      end
   end

   assign rom_addr = rom_addr_q;
   assign pdm_clk  = pdm_clk_q;
   assign pdm_out  = pdm_out_q;
   assign busy     = busy_q;
   assign overrun  = overrun_q;

endmodule
